// File: rtl/intc_mux.sv
// intc_mux: 8-line priority interrupt multiplexer with edge-latched pending bits,
// a mask register and a post-acknowledge holdoff. Optional ASSERT timeout under INTC_TIMEOUT_EN.
module intc_mux #(
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       ack,
    input  logic       mask_we,
    input  logic [7:0] mask_wdata,
    output logic       interrupt,
    output logic [2:0] irq,
    output logic [7:0] pending,
    output logic [7:0] mask,
    output logic       lost
);

    localparam int unsigned N_LINES = 8;
    localparam int unsigned IRQ_W   = 3;
    localparam int unsigned HOLD_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Out-of-range parameters are rejected at elaboration.
    if (HOLDOFF == 0 || HOLDOFF > 255) begin : g_bad_holdoff
        $error("intc_mux: HOLDOFF must be in 1..255");
    end
    if (TIMEOUT == 0 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("intc_mux: TIMEOUT must be in 1..65535");
    end

    state_t              state;
    state_t              state_next;
    logic [N_LINES-1:0]  prev_req;
    logic [N_LINES-1:0]  req_rise;
    logic [N_LINES-1:0]  grant;
    logic [N_LINES-1:0]  clr;
    logic [N_LINES-1:0]  pending_next;
    logic [N_LINES-1:0]  mask_next;
    logic [IRQ_W-1:0]    irq_next;
    logic                interrupt_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_next;
    logic                launch;

`ifdef INTC_TIMEOUT_EN
    localparam int unsigned TMO_W = 16;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [TMO_W-1:0]    tmo_cnt_next;
    logic                lost_next;
`endif

    function automatic logic [IRQ_W-1:0] lowest_set(input logic [N_LINES-1:0] v);
        logic [IRQ_W-1:0] idx;
        idx = '0;
        for (int i = int'(N_LINES) - 1; i >= 0; i--) begin
            if (v[i]) idx = IRQ_W'(i);
        end
        return idx;
    endfunction

    assign req_rise = req & ~prev_req;
    // Arbitration always sees the registered mask, so a same-cycle write takes effect next clock.
    assign grant    = pending & ~mask;

    always_comb begin
        state_next     = state;
        irq_next       = irq;
        interrupt_next = interrupt;
        hold_cnt_next  = hold_cnt;
        clr            = '0;
        launch         = 1'b0;
        mask_next      = mask_we ? mask_wdata : mask;
`ifdef INTC_TIMEOUT_EN
        tmo_cnt_next   = tmo_cnt;
        lost_next      = lost;
`endif

        case (state)
            IDLE: begin
                launch = |grant;
            end
            ASSERT: begin
                if (ack) begin
                    clr[irq]       = 1'b1;
                    interrupt_next = 1'b0;
                    hold_cnt_next  = HOLD_W'(HOLDOFF);
                    state_next     = HOLD;
`ifdef INTC_TIMEOUT_EN
                end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    // Give up on the CPU; the line stays pending for a later retry.
                    interrupt_next = 1'b0;
                    lost_next      = 1'b1;
                    hold_cnt_next  = HOLD_W'(HOLDOFF);
                    state_next     = HOLD;
                end else begin
                    tmo_cnt_next   = tmo_cnt + TMO_W'(1);
`endif
                end
            end
            HOLD: begin
                // The edge that empties the counter also arbitrates, giving exactly HOLDOFF low clocks.
                if (hold_cnt <= HOLD_W'(1)) begin
                    hold_cnt_next = '0;
                    state_next    = IDLE;
                    launch        = |grant;
                end else begin
                    hold_cnt_next = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_next     = IDLE;
                interrupt_next = 1'b0;
            end
        endcase

        if (launch) begin
            irq_next       = lowest_set(grant);
            interrupt_next = 1'b1;
            state_next     = ASSERT;
`ifdef INTC_TIMEOUT_EN
            tmo_cnt_next   = '0;
`endif
        end

        // A new edge on the line being cleared wins over the clear.
        pending_next = (pending & ~clr) | req_rise;
    end

    always_ff @(posedge clock) begin
        prev_req <= req;
        if (reset) begin
            state     <= IDLE;
            interrupt <= 1'b0;
            irq       <= '0;
            pending   <= '0;
            mask      <= '0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_next;
            interrupt <= interrupt_next;
            irq       <= irq_next;
            pending   <= pending_next;
            mask      <= mask_next;
            hold_cnt  <= hold_cnt_next;
        end
    end

`ifdef INTC_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            tmo_cnt <= '0;
            lost    <= 1'b0;
        end else begin
            tmo_cnt <= tmo_cnt_next;
            lost    <= lost_next;
        end
    end
`else
    assign lost = 1'b0;
`endif

endmodule
